sha3_msg_feeder: RTL and testbench
==================================

Name: sha3_msg_feeder

Overview:
- Upstream stage of the SHA3 controller's TL-UL adapter: converts a byte stream into valid-hold (VH) register writes.
- Sequences one hash:
  - CMD=START write.
  - Packed 32-bit little-endian writes to the message FIFO window, with byte strobes on the final partial word.
  - CMD=PROCESS write.
- Lets a hardware client (e.g. the key-derivation path) hash without firmware involvement.

Parameters:
- ADDR_WIDTH, 32, VH address width.
- MSG_FIFO_ADDR, 32'h0000_0800, message FIFO window base; every data write goes to this address.
- CMD_ADDR, 32'h0000_0018, command register address.
- CMD_START, 32'h0000_001D, value written to start a hash.
- CMD_PROCESS, 32'h0000_002E, value written to finish absorption.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- start_i  in  1  one-cycle pulse; begins a hash; ignored unless IDLE.
- empty_msg_i  in  1  sampled with start_i; 1 = zero-length message, skip STREAM.
- s_valid_i  in  1  byte valid.
- s_ready_o  out  1  byte accepted when s_valid_i && s_ready_o.
- s_data_i  in  8  message byte.
- s_last_i  in  1  marks final byte.
- dv_o  out  1  VH request valid.
- hld_i  in  1  VH hold; request completes in the first cycle with dv_o=1 and hld_i=0.
- addr_o  out  ADDR_WIDTH  VH address.
- write_o  out  1  always 1 when dv_o.
- wdata_o  out  32  VH write data.
- wstrb_o  out  4  byte enables.
- error_i  in  1  VH error; valid in the completing cycle.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse after PROCESS completes.
- err_o  out  1  sticky error; cleared by the next accepted start_i.

Behaviour:
- Reset (synchronous on clk, reset_n=0):
  - state=IDLE.
  - All outputs 0; wdata_o=0, wstrb_o=0, addr_o=0.
  - Pack buffer and byte index cleared.
  - Reset mid-operation abandons the transfer with no further VH activity; an in-flight dv_o drops the cycle after reset is sampled.
- States: IDLE, CMD_START, STREAM, WR_DATA, CMD_PROC, DONE, ERROR.
- IDLE:
  - start_i → CMD_START; latch empty_msg_i; clear err_o.
- CMD_START:
  - dv_o=1, addr_o=CMD_ADDR, wdata_o=CMD_START, wstrb_o=4'hF.
  - On completion: if error_i → ERROR; elif empty → CMD_PROC; else → STREAM.
- STREAM:
  - s_ready_o=1.
  - Accepted byte stored at lane idx; idx increments mod 4.
  - When the 4th lane fills or s_last_i is accepted → WR_DATA the next cycle; s_ready_o=0 from that cycle on.
  - wstrb: idx=0→4'h1, 1→4'h3, 2→4'h7, full→4'hF.
  - Unused lanes are 0.
- WR_DATA:
  - dv_o=1, addr_o=MSG_FIFO_ADDR, buffered word and strobe driven.
  - Outputs are stable while hld_i=1.
  - On completion: error_i → ERROR; elif the word held the last byte → CMD_PROC; else → STREAM with idx=0.
- CMD_PROC:
  - As CMD_START, but with CMD_PROCESS.
  - On completion: error_i → ERROR; else → DONE.
- DONE:
  - done_o=1 for one cycle → IDLE.
- ERROR:
  - err_o=1 (sticky), done_o=1 for one cycle → IDLE.
  - Bytes are not drained.
- Throughput: 4 bytes per 5 cycles minimum (4 accept cycles plus 1 write cycle with hld_i=0).
- Latency: s_last_i accept → done_o is 3 cycles minimum (data write, PROCESS write, DONE).
- dv_o never drops while hld_i=1 except on reset.
- start_i while busy is ignored.
- s_last_i on the 4th lane produces one full word, not an extra empty word.

Optional Feature:
- Macro: SHA3_MSG_FEEDER_BYTE_CNT_EN.
- When defined:
  - Adds output msg_bytes_o[63:0], the count of bytes accepted in the current hash.
  - Cleared on accepted start_i; increments per accepted byte; saturates at all-ones.
  - Holds its value after DONE or ERROR until the next start.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sha3_msg_feeder_pkg:
  - State enum.
  - Default CMD_START/CMD_PROCESS encodings.
  - Function idx_to_strb.
- Sub-module sha3_byte_packer:
  - Lane buffer, idx, strobe generation, last flag.
  - load/clear interface driven by the top FSM.

Test Plan:
- Message "abcde" (61..65), hld_i=0 → writes in order:
  - CMD_ADDR 0x1D, strb F.
  - 0x800 data 0x64636261, strb F.
  - 0x800 data 0x00000065, strb 1.
  - CMD_ADDR 0x2E.
  - Then done_o pulse; err_o=0.
- start_i with empty_msg_i=1 → only the 0x1D and 0x2E writes, no FIFO write; done_o 3 cycles after start minimum.
- 8-byte message with hld_i=1 for 3 cycles on each write → exactly two FIFO writes, strb F each, no trailing write; dv_o/addr_o/wdata_o stable during hold; s_ready_o=0 throughout.
- error_i=1 on the first FIFO write → ERROR; err_o=1; no PROCESS write; done_o pulses; next start_i clears err_o.
- reset_n=0 during STREAM after 2 bytes → next cycle all outputs 0; a fresh 1-byte message 0xAA yields data 0x000000AA, strb 1.
- SHA3_MSG_FEEDER_BYTE_CNT_EN: 13-byte message → msg_bytes_o=13 after DONE; last write strb 1; reset to 0 on next start.

Source files
------------

// File: rtl/sha3_msg_feeder_pkg.sv
// Shared types and constants for the SHA3 message feeder.
package sha3_msg_feeder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmdStart,
    StStream,
    StWrData,
    StCmdProc,
    StDone,
    StError
  } state_e;

  localparam logic [31:0] CmdStartDefault   = 32'h0000_001D;
  localparam logic [31:0] CmdProcessDefault = 32'h0000_002E;

  // Byte enables for a word whose highest filled lane is idx.
  function automatic logic [3:0] idx_to_strb(input logic [1:0] idx);
    logic [3:0] strb;
    unique case (idx)
      2'd0:    strb = 4'h1;
      2'd1:    strb = 4'h3;
      2'd2:    strb = 4'h7;
      default: strb = 4'hF;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sha3_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word with matching byte strobes.
module sha3_byte_packer
  import sha3_msg_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  output logic        flush_o,
  output logic [31:0] word_o,
  output logic [3:0]  strb_o,
  output logic        last_o
);

  logic [3:0][7:0] r_lane;
  logic [1:0]      r_idx;
  logic [1:0]      r_top;
  logic            r_last;

  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      r_lane <= '0;
      r_idx  <= '0;
      r_top  <= '0;
      r_last <= 1'b0;
    end else if (load_i) begin
      r_lane[r_idx] <= data_i;
      r_top         <= r_idx;
      r_idx         <= r_idx + 2'd1;
      if (last_i) r_last <= 1'b1;
    end
  end

  // Word is complete when this byte fills lane 3 or ends the message.
  assign flush_o = load_i && ((r_idx == 2'd3) || last_i);
  assign word_o  = r_lane;
  assign strb_o  = idx_to_strb(r_top);
  assign last_o  = r_last;

endmodule

// File: rtl/sha3_msg_feeder.sv
// Byte stream to SHA3 valid-hold register writes: START, packed FIFO words, PROCESS.
// Optional byte counter output enabled by SHA3_MSG_FEEDER_BYTE_CNT_EN.
module sha3_msg_feeder
  import sha3_msg_feeder_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0]   MSG_FIFO_ADDR = 32'h0000_0800,
  parameter logic [ADDR_WIDTH-1:0]   CMD_ADDR      = 32'h0000_0018,
  parameter logic [31:0]             CMD_START     = CmdStartDefault,
  parameter logic [31:0]             CMD_PROCESS   = CmdProcessDefault
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic                  empty_msg_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [7:0]            s_data_i,
  input  logic                  s_last_i,
  output logic                  dv_o,
  input  logic                  hld_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  write_o,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wstrb_o,
  input  logic                  error_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
`ifdef SHA3_MSG_FEEDER_BYTE_CNT_EN
  ,
  output logic [63:0]           msg_bytes_o
`endif
);

  state_e      r_state, w_state_d;
  logic        r_empty, w_empty_d;
  logic        r_err, w_err_d;
  logic        w_load, w_clear, w_flush, w_last;
  logic [31:0] w_word;
  logic [3:0]  w_strb;

  sha3_byte_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (w_clear),
    .load_i  (w_load),
    .data_i  (s_data_i),
    .last_i  (s_last_i),
    .flush_o (w_flush),
    .word_o  (w_word),
    .strb_o  (w_strb),
    .last_o  (w_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_empty <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_empty <= w_empty_d;
      r_err   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_empty_d = r_empty;
    w_err_d   = r_err;
    w_load    = 1'b0;
    w_clear   = 1'b0;
    dv_o      = 1'b0;
    addr_o    = '0;
    wdata_o   = '0;
    wstrb_o   = '0;
    s_ready_o = 1'b0;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    unique case (r_state)
      StIdle: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_state_d = StCmdStart;
          w_empty_d = empty_msg_i;
          w_err_d   = 1'b0;
          w_clear   = 1'b1;
        end
      end
      StCmdStart: begin
        dv_o    = 1'b1;
        addr_o  = CMD_ADDR;
        wdata_o = CMD_START;
        wstrb_o = 4'hF;
        if (!hld_i) begin
          if (error_i) begin
            w_state_d = StError;
            w_err_d   = 1'b1;
          end else if (r_empty) begin
            w_state_d = StCmdProc;
          end else begin
            w_state_d = StStream;
          end
        end
      end
      StStream: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          w_load = 1'b1;
          if (w_flush) w_state_d = StWrData;
        end
      end
      StWrData: begin
        dv_o    = 1'b1;
        addr_o  = MSG_FIFO_ADDR;
        wdata_o = w_word;
        wstrb_o = w_strb;
        if (!hld_i) begin
          if (error_i) begin
            w_state_d = StError;
            w_err_d   = 1'b1;
          end else if (w_last) begin
            w_state_d = StCmdProc;
          end else begin
            // Next word starts from lane 0 with unused lanes zeroed.
            w_state_d = StStream;
            w_clear   = 1'b1;
          end
        end
      end
      StCmdProc: begin
        dv_o    = 1'b1;
        addr_o  = CMD_ADDR;
        wdata_o = CMD_PROCESS;
        wstrb_o = 4'hF;
        if (!hld_i) begin
          if (error_i) begin
            w_state_d = StError;
            w_err_d   = 1'b1;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        done_o    = 1'b1;
        w_state_d = StIdle;
      end
      StError: begin
        done_o    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign write_o = dv_o;
  assign err_o   = r_err;

`ifdef SHA3_MSG_FEEDER_BYTE_CNT_EN
  logic [63:0] r_byte_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_byte_cnt <= '0;
    end else if (r_state == StIdle && start_i) begin
      r_byte_cnt <= '0;
    end else if (w_load && (r_byte_cnt != '1)) begin
      r_byte_cnt <= r_byte_cnt + 64'd1;
    end
  end

  assign msg_bytes_o = r_byte_cnt;
`endif

endmodule

// File: tb/tb_sha3_msg_feeder.sv
// Directed table-driven bench for sha3_msg_feeder: one record per message with its expected writes.
module tb_sha3_msg_feeder;

  localparam logic [31:0] FifoA = 32'h0000_0800;
  localparam logic [31:0] CmdA  = 32'h0000_0018;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic        empty_msg_i = 1'b0;
  logic        s_valid_i = 1'b0;
  logic [7:0]  s_data_i = 8'h00;
  logic        s_last_i = 1'b0;
  logic        hld_i = 1'b0;
  logic        error_i = 1'b0;
  logic        s_ready_o, dv_o, write_o, busy_o, done_o, err_o;
  logic [31:0] addr_o, wdata_o;
  logic [3:0]  wstrb_o;
`ifdef SHA3_MSG_FEEDER_BYTE_CNT_EN
  logic [63:0] msg_bytes_o;
`endif

  always #5 clk = ~clk;

  sha3_msg_feeder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .empty_msg_i (empty_msg_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .s_last_i    (s_last_i),
    .dv_o        (dv_o),
    .hld_i       (hld_i),
    .addr_o      (addr_o),
    .write_o     (write_o),
    .wdata_o     (wdata_o),
    .wstrb_o     (wstrb_o),
    .error_i     (error_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
`ifdef SHA3_MSG_FEEDER_BYTE_CNT_EN
    ,
    .msg_bytes_o (msg_bytes_o)
`endif
  );

  typedef struct {
    logic [127:0] msg;
    int           len;
    int           hold;
    bit           errf;
    bit           exp_err;
    int           lat;
    int           bytes;
    int           n_wr;
    int           wr_base;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  vec_t vecs[$];
  wr_t  wrs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add_vec(input logic [127:0] msg, input int len, input int hold,
                                  input bit errf, input bit exp_err, input int lat,
                                  input int bytes, input int n_wr);
    vec_t v;
    v.msg = msg; v.len = len; v.hold = hold; v.errf = errf; v.exp_err = exp_err;
    v.lat = lat; v.bytes = bytes; v.n_wr = n_wr; v.wr_base = wrs.size();
    vecs.push_back(v);
  endfunction

  function automatic void add_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.addr = a; w.data = d; w.strb = s;
    wrs.push_back(w);
  endfunction

  function automatic logic [127:0] outs();
    return 128'({dv_o, s_ready_o, write_o, busy_o, done_o, err_o, addr_o, wdata_o, wstrb_o});
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t        v;
    wr_t         e;
    int          c, ptr, wr, held;
    bit          done_seen;
    logic [67:0] cap;
    v = vecs[vi];
    c = 0; ptr = 0; wr = 0; held = 0; done_seen = 1'b0; cap = '0;
    start_i = 1'b1;
    empty_msg_i = (v.len == 0);
    @(posedge clk);
    while (!done_seen && c < 300) begin
      @(negedge clk);
      c++;
      // A start pulse while busy must be ignored.
      start_i = (c == 2);
      empty_msg_i = (c == 2);
      if (c == 1) begin
        chk($sformatf("v%0d_start_state", vi), 128'({busy_o, err_o, dv_o}), 128'(3'b101));
`ifdef SHA3_MSG_FEEDER_BYTE_CNT_EN
        chk($sformatf("v%0d_cnt_clear", vi), 128'(msg_bytes_o), 128'(0));
`endif
      end
      s_valid_i = (ptr < v.len);
      s_data_i = v.msg[8*ptr +: 8];
      s_last_i = (ptr == v.len - 1);
      hld_i = 1'b0;
      error_i = 1'b0;
      if (dv_o) begin
        if (held == 0) begin
          cap = {addr_o, wdata_o, wstrb_o};
        end else begin
          chk($sformatf("v%0d_hold_stable", vi), 128'({addr_o, wdata_o, wstrb_o, s_ready_o}),
              128'({cap, 1'b0}));
        end
        if (held < v.hold) begin
          hld_i = 1'b1;
          held++;
        end else begin
          held = 0;
          if (v.errf && addr_o == FifoA) error_i = 1'b1;
          if (wr < v.n_wr) begin
            e = wrs[v.wr_base + wr];
            chk($sformatf("v%0d_wr%0d", vi, wr), 128'({addr_o, wdata_o, wstrb_o}),
                128'({e.addr, e.data, e.strb}));
          end else begin
            chk($sformatf("v%0d_extra_wr", vi), 128'(wr), 128'(v.n_wr));
          end
          chk($sformatf("v%0d_wr_ctl", vi), 128'({write_o, s_ready_o}), 128'(2'b10));
          wr++;
        end
      end else if (held > 0) begin
        chk($sformatf("v%0d_dv_drop", vi), 128'(dv_o), 128'(1));
        held = 0;
      end
      if (s_valid_i && s_ready_o) ptr++;
      if (done_o) begin
        done_seen = 1'b1;
        chk($sformatf("v%0d_err", vi), 128'(err_o), 128'(v.exp_err));
        chk($sformatf("v%0d_n_wr", vi), 128'(wr), 128'(v.n_wr));
        if (v.lat >= 0) chk($sformatf("v%0d_latency", vi), 128'(c), 128'(v.lat));
        if (!v.exp_err) chk($sformatf("v%0d_bytes_used", vi), 128'(ptr), 128'(v.len));
`ifdef SHA3_MSG_FEEDER_BYTE_CNT_EN
        chk($sformatf("v%0d_msg_bytes", vi), 128'(msg_bytes_o), 128'(v.bytes));
`endif
      end
    end
    if (!done_seen) chk($sformatf("v%0d_timeout", vi), 128'(done_seen), 128'(1));
    start_i = 1'b0; empty_msg_i = 1'b0; s_valid_i = 1'b0; s_last_i = 1'b0;
    hld_i = 1'b0; error_i = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", vi), 128'({done_o, busy_o, err_o}),
        128'({2'b00, v.exp_err}));
  endtask

  initial begin
    // 0: "abcde"
    add_vec(128'h65_6463_6261, 5, 0, 1'b0, 1'b0, 10, 5, 4);
    add_wr(CmdA, 32'h1D, 4'hF); add_wr(FifoA, 32'h64636261, 4'hF);
    add_wr(FifoA, 32'h00000065, 4'h1); add_wr(CmdA, 32'h2E, 4'hF);
    // 1: empty message
    add_vec(128'h0, 0, 0, 1'b0, 1'b0, 3, 0, 2);
    add_wr(CmdA, 32'h1D, 4'hF); add_wr(CmdA, 32'h2E, 4'hF);
    // 2: 8 bytes, 3 hold cycles on every write
    add_vec(128'h0807060504030201, 8, 3, 1'b0, 1'b0, -1, 8, 4);
    add_wr(CmdA, 32'h1D, 4'hF); add_wr(FifoA, 32'h04030201, 4'hF);
    add_wr(FifoA, 32'h08070605, 4'hF); add_wr(CmdA, 32'h2E, 4'hF);
    // 3: error on first FIFO write
    add_vec(128'h65_6463_6261, 5, 0, 1'b1, 1'b1, -1, 4, 2);
    add_wr(CmdA, 32'h1D, 4'hF); add_wr(FifoA, 32'h64636261, 4'hF);
    // 4: 3 bytes, hold 1
    add_vec(128'h332211, 3, 1, 1'b0, 1'b0, -1, 3, 3);
    add_wr(CmdA, 32'h1D, 4'hF); add_wr(FifoA, 32'h00332211, 4'h7); add_wr(CmdA, 32'h2E, 4'hF);
    // 5: 6 bytes
    add_vec(128'h060504030201, 6, 0, 1'b0, 1'b0, -1, 6, 4);
    add_wr(CmdA, 32'h1D, 4'hF); add_wr(FifoA, 32'h04030201, 4'hF);
    add_wr(FifoA, 32'h00000605, 4'h3); add_wr(CmdA, 32'h2E, 4'hF);
    // 6: 7 bytes
    add_vec(128'h07060504030201, 7, 0, 1'b0, 1'b0, -1, 7, 4);
    add_wr(CmdA, 32'h1D, 4'hF); add_wr(FifoA, 32'h04030201, 4'hF);
    add_wr(FifoA, 32'h00070605, 4'h7); add_wr(CmdA, 32'h2E, 4'hF);
    // 7: 4 bytes, last on lane 3
    add_vec(128'h04030201, 4, 0, 1'b0, 1'b0, 8, 4, 3);
    add_wr(CmdA, 32'h1D, 4'hF); add_wr(FifoA, 32'h04030201, 4'hF); add_wr(CmdA, 32'h2E, 4'hF);
    // 8: 13 bytes
    add_vec(128'h0D0C0B0A090807060504030201, 13, 0, 1'b0, 1'b0, -1, 13, 6);
    add_wr(CmdA, 32'h1D, 4'hF); add_wr(FifoA, 32'h04030201, 4'hF);
    add_wr(FifoA, 32'h08070605, 4'hF); add_wr(FifoA, 32'h0C0B0A09, 4'hF);
    add_wr(FifoA, 32'h0000000D, 4'h1); add_wr(CmdA, 32'h2E, 4'hF);
    // 9: single byte after a mid-stream reset
    add_vec(128'hAA, 1, 0, 1'b0, 1'b0, 5, 1, 3);
    add_wr(CmdA, 32'h1D, 4'hF); add_wr(FifoA, 32'h000000AA, 4'h1); add_wr(CmdA, 32'h2E, 4'hF);

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), 128'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset during STREAM after two accepted bytes.
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    s_valid_i = 1'b1; s_data_i = 8'h11; s_last_i = 1'b0;
    @(negedge clk);
    s_data_i = 8'h22;
    @(negedge clk);
    chk("pre_reset_busy", 128'({busy_o, s_ready_o}), 128'(2'b11));
    s_valid_i = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_outs", outs(), 128'(0));
`ifdef SHA3_MSG_FEEDER_BYTE_CNT_EN
    chk("mid_reset_cnt", 128'(msg_bytes_o), 128'(0));
`endif
    reset_n = 1'b1;
    @(negedge clk);
    run_vec(9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
